// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-to-ALU stage bundle with forwarding taps
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int OP_W   = 7
);
    logic              in_valid;
    logic [OP_W-1:0]   in_opcode;
    logic [REG_W-1:0]  in_rs1;
    logic [REG_W-1:0]  in_rs2;
    logic [DATA_W-1:0] in_rs1_data;
    logic [DATA_W-1:0] in_rs2_data;
    logic [REG_W-1:0]  in_rd;
    logic              in_wr_en;
    logic              in_is_load;
    logic              stall_in;
    logic              flush;
    logic              mem_wr_en;
    logic [REG_W-1:0]  mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              wb_wr_en;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic [OP_W-1:0]   out_opcode;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [REG_W-1:0]  out_rd;
    logic              out_wr_en;
    logic              out_is_load;
    logic              upstream_stall;

    modport master (
        output in_valid, in_opcode, in_rs1, in_rs2, in_rs1_data, in_rs2_data,
               in_rd, in_wr_en, in_is_load, stall_in, flush,
               mem_wr_en, mem_rd, mem_data, wb_wr_en, wb_rd, wb_data,
        input  out_valid, out_opcode, out_a, out_b, out_rd, out_wr_en,
               out_is_load, upstream_stall
    );

    modport slave (
        input  in_valid, in_opcode, in_rs1, in_rs2, in_rs1_data, in_rs2_data,
               in_rd, in_wr_en, in_is_load, stall_in, flush,
               mem_wr_en, mem_rd, mem_data, wb_wr_en, wb_rd, wb_data,
        output out_valid, out_opcode, out_a, out_b, out_rd, out_wr_en,
               out_is_load, upstream_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use bubbles
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int OP_W   = 7
) (
    input logic           clock,
    input logic           reset,
    id_ex_stage_if.slave  bus
);
    logic              valid;
    logic              wr_en;
    logic              is_load;
    logic [OP_W-1:0]   opcode;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic              lu;

    // MEM result is younger than WB, so it wins; register 0 is never forwarded.
    always_comb begin
        fwd_a = rs1_val;
        if (rs1 != '0) begin
            if (bus.mem_wr_en && bus.mem_rd == rs1)
                fwd_a = bus.mem_data;
            else if (bus.wb_wr_en && bus.wb_rd == rs1)
                fwd_a = bus.wb_data;
        end
        fwd_b = rs2_val;
        if (rs2 != '0) begin
            if (bus.mem_wr_en && bus.mem_rd == rs2)
                fwd_b = bus.mem_data;
            else if (bus.wb_wr_en && bus.wb_rd == rs2)
                fwd_b = bus.wb_data;
        end
    end

    // The register file is written in the same cycle it is read, so take the WB value directly.
    always_comb begin
        cap_a = bus.in_rs1_data;
        cap_b = bus.in_rs2_data;
        if (bus.wb_wr_en && bus.wb_rd == bus.in_rs1 && bus.in_rs1 != '0)
            cap_a = bus.wb_data;
        if (bus.wb_wr_en && bus.wb_rd == bus.in_rs2 && bus.in_rs2 != '0)
            cap_b = bus.wb_data;
    end

    always_comb begin
        lu = valid && is_load && bus.in_valid &&
             ((bus.in_rs1 == rd && bus.in_rs1 != '0) ||
              (bus.in_rs2 == rd && bus.in_rs2 != '0));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid   <= 1'b0;
            wr_en   <= 1'b0;
            is_load <= 1'b0;
            opcode  <= '0;
            rs1     <= '0;
            rs2     <= '0;
            rd      <= '0;
            rs1_val <= '0;
            rs2_val <= '0;
        end else if (bus.flush) begin
            valid   <= 1'b0;
            wr_en   <= 1'b0;
            is_load <= 1'b0;
        end else if (bus.stall_in) begin
            // Latch forwarded operands so a source that retires during the stall is not lost.
            rs1_val <= fwd_a;
            rs2_val <= fwd_b;
        end else if (lu) begin
            valid   <= 1'b0;
            wr_en   <= 1'b0;
            is_load <= 1'b0;
        end else begin
            valid   <= bus.in_valid;
            wr_en   <= bus.in_wr_en & bus.in_valid;
            is_load <= bus.in_is_load & bus.in_valid;
            opcode  <= bus.in_opcode;
            rs1     <= bus.in_rs1;
            rs2     <= bus.in_rs2;
            rd      <= bus.in_rd;
            rs1_val <= cap_a;
            rs2_val <= cap_b;
        end
    end

    assign bus.out_valid      = valid;
    assign bus.out_opcode     = opcode;
    assign bus.out_a          = fwd_a;
    assign bus.out_b          = fwd_b;
    assign bus.out_rd         = rd;
    assign bus.out_wr_en      = wr_en & valid;
    assign bus.out_is_load    = is_load & valid;
    assign bus.upstream_stall = bus.stall_in | lu;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage with directed vectors
module tb_id_ex_stage;
    logic clock;
    logic reset;

    id_ex_stage_if #(.DATA_W(32), .REG_W(5), .OP_W(7)) bus ();

    id_ex_stage #(.DATA_W(32), .REG_W(5), .OP_W(7)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [7:0]  mask;
        logic        v;
        logic [6:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wr;
        logic        ld;
        logic        st;
    } exp_t;

    localparam logic [7:0] M_V = 8'h01, M_OP = 8'h02, M_A = 8'h04, M_B = 8'h08,
                           M_RD = 8'h10, M_WR = 8'h20, M_LD = 8'h40, M_ST = 8'h80;
    localparam logic [7:0] M_ALL = 8'hFF;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic expect_state(input string name, input logic [7:0] mask, input logic v,
                                input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic wr, input logic ld, input logic st);
        exp_t e;
        e.name = name; e.mask = mask; e.v = v; e.op = op; e.a = a; e.b = b;
        e.rd = rd; e.wr = wr; e.ld = ld; e.st = st;
        sb.push_back(e);
    endtask

    task automatic cmp(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s got 0x%0h expected 0x%0h", name, field, act, req);
        end
    endtask

    // Monitor: compares every pending expectation against what the DUT presents mid-cycle.
    always @(negedge clock) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.mask[0]) cmp(e.name, "out_valid", {31'b0, bus.out_valid}, {31'b0, e.v});
            if (e.mask[1]) cmp(e.name, "out_opcode", {25'b0, bus.out_opcode}, {25'b0, e.op});
            if (e.mask[2]) cmp(e.name, "out_a", bus.out_a, e.a);
            if (e.mask[3]) cmp(e.name, "out_b", bus.out_b, e.b);
            if (e.mask[4]) cmp(e.name, "out_rd", {27'b0, bus.out_rd}, {27'b0, e.rd});
            if (e.mask[5]) cmp(e.name, "out_wr_en", {31'b0, bus.out_wr_en}, {31'b0, e.wr});
            if (e.mask[6]) cmp(e.name, "out_is_load", {31'b0, bus.out_is_load}, {31'b0, e.ld});
            if (e.mask[7]) cmp(e.name, "upstream_stall", {31'b0, bus.upstream_stall}, {31'b0, e.st});
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_instr(input logic v, input logic [6:0] op, input logic [4:0] r1,
                               input logic [31:0] d1, input logic [4:0] r2, input logic [31:0] d2,
                               input logic [4:0] rd, input logic wr, input logic ld);
        bus.in_valid = v; bus.in_opcode = op;
        bus.in_rs1 = r1; bus.in_rs1_data = d1;
        bus.in_rs2 = r2; bus.in_rs2_data = d2;
        bus.in_rd = rd; bus.in_wr_en = wr; bus.in_is_load = ld;
    endtask

    task automatic drive_fwd(input logic me, input logic [4:0] mr, input logic [31:0] md,
                             input logic we, input logic [4:0] wr, input logic [31:0] wd);
        bus.mem_wr_en = me; bus.mem_rd = mr; bus.mem_data = md;
        bus.wb_wr_en = we; bus.wb_rd = wr; bus.wb_data = wd;
    endtask

    initial begin
        reset = 1'b1;
        drive_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_fwd(0, 0, 0, 0, 0, 0);
        bus.stall_in = 1'b0;
        bus.flush = 1'b0;

        step();
        expect_state("reset", M_ALL, 0, 7'h00, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        drive_instr(1, 7'h33, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 1, 0);
        step();
        drive_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_state("capture", M_ALL, 1, 7'h33, 5, 7, 3, 1, 0, 0);

        // Asynchronous reset while an instruction is held, then recapture.
        step();
        reset = 1'b1;
        #1;
        expect_state("mid_reset", M_V | M_WR | M_OP | M_RD, 0, 7'h00, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        drive_instr(1, 7'h33, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 1, 0);
        step();
        expect_state("post_reset_add", M_V | M_OP | M_A | M_B, 1, 7'h33, 5, 7, 0, 0, 0, 0);

        // Forwarding priority on rs1=3.
        drive_instr(1, 7'h01, 5'd3, 32'h100, 5'd4, 32'h200, 5'd8, 1, 0);
        step();
        drive_fwd(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
        expect_state("fwd_mem_wins", M_A | M_B, 0, 0, 32'h11, 32'h200, 0, 0, 0, 0);
        step();
        bus.mem_wr_en = 1'b0;
        bus.in_rs1 = 5'd0;
        expect_state("fwd_wb", M_A | M_V, 1, 0, 32'h22, 0, 0, 0, 0, 0);
        step();
        drive_fwd(1, 5'd0, 32'h11, 1, 5'd0, 32'h22);
        expect_state("fwd_r0", M_A | M_B, 0, 0, 32'h100, 32'h200, 0, 0, 0, 0);
        step();
        drive_fwd(0, 0, 0, 0, 0, 0);

        // Load-use hazard: load rd=4, dependent reads rs2=4.
        drive_instr(1, 7'h03, 5'd1, 32'h10, 5'd0, 32'h0, 5'd4, 1, 1);
        step();
        drive_instr(1, 7'h33, 5'd5, 32'h50, 5'd4, 32'hAA, 5'd6, 1, 0);
        expect_state("lu_detect", M_V | M_LD | M_RD | M_ST, 1, 0, 0, 0, 4, 0, 1, 1);
        step();
        drive_fwd(0, 0, 0, 1, 5'd4, 32'h99);
        expect_state("lu_bubble", M_V | M_WR | M_LD | M_ST, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive_fwd(0, 0, 0, 0, 0, 0);
        drive_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_state("lu_dependent", M_ALL, 1, 7'h33, 32'h50, 32'h99, 6, 1, 0, 0);

        // Stall refresh keeps a WB-forwarded operand after the forward disappears.
        drive_instr(1, 7'h13, 5'd6, 32'h60, 5'd0, 32'h7, 5'd7, 1, 0);
        step();
        bus.stall_in = 1'b1;
        drive_instr(1, 7'h7F, 5'd9, 32'hDEAD, 5'd9, 32'hBEEF, 5'd9, 0, 1);
        drive_fwd(0, 0, 0, 1, 5'd6, 32'h55);
        expect_state("stall_fwd", M_A | M_OP | M_ST, 0, 7'h13, 32'h55, 0, 0, 0, 0, 1);
        step();
        drive_fwd(0, 0, 0, 0, 0, 0);
        expect_state("stall_hold", M_ALL, 1, 7'h13, 32'h55, 32'h7, 7, 1, 0, 1);

        // Flush beats stall on the held writer.
        step();
        bus.flush = 1'b1;
        expect_state("flush_cycle", M_V | M_ST, 1, 0, 0, 0, 0, 0, 0, 1);
        step();
        bus.flush = 1'b0;
        bus.stall_in = 1'b0;
        drive_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_state("flushed", M_V | M_WR | M_LD, 0, 0, 0, 0, 0, 0, 0, 0);

        // Capture bypass from the same-cycle register-file write.
        step();
        drive_instr(1, 7'h33, 5'd9, 32'h1, 5'd0, 32'h0, 5'd10, 1, 0);
        drive_fwd(0, 0, 0, 1, 5'd9, 32'h77);
        step();
        drive_fwd(0, 0, 0, 0, 0, 0);
        drive_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_state("cap_bypass", M_V | M_A | M_RD, 1, 0, 32'h77, 0, 10, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
